// File: rtl/imm_gen_pkg.sv
`default_nettype none
//============================================================================
// Module   : imm_gen_pkg
// Brief    : Shared types and opcode match constants for the LEGv8
//            pipelined immediate generator.
// Revision : 1.0 - initial release
//============================================================================
package imm_gen_pkg;

    // Kind of immediate carried alongside the instruction
    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_B     = 3'd1,
        IMM_CB    = 3'd2,
        IMM_D     = 3'd3,
        IMM_I     = 3'd4,
        IMM_SHAMT = 3'd5,
        IMM_IW    = 3'd6
    } imm_type_e;

    // Opcode match values, MSB-aligned to Instr[31]
    localparam logic [5:0]  C_OP_B    = 6'b000101;      // [31:26]
    localparam logic [5:0]  C_OP_BL   = 6'b100101;      // [31:26]
    localparam logic [7:0]  C_OP_CBZ  = 8'b10110100;    // [31:24]
    localparam logic [7:0]  C_OP_CBNZ = 8'b10110101;    // [31:24]
    localparam logic [10:0] C_OP_STUR = 11'b11111000000; // [31:21]
    localparam logic [10:0] C_OP_LDUR = 11'b11111000010; // [31:21]
    localparam logic [9:0]  C_OP_ADDI = 10'b1001000100;  // [31:22]
    localparam logic [9:0]  C_OP_SUBI = 10'b1101000100;  // [31:22]
    localparam logic [10:0] C_OP_LSL  = 11'b11010011011; // [31:21]
    localparam logic [10:0] C_OP_LSR  = 11'b11010011010; // [31:21]
    localparam logic [8:0]  C_OP_MOVZ = 9'b110100101;    // [31:23]

    // Only 32- and 64-bit datapaths are supported
    function automatic bit data_w_legal(input int w);
        return (w == 32) || (w == 64);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
//============================================================================
// Module   : imm_gen_pipe_if
// Brief    : Input/output handshake bundle of the immediate generator.
//            slave  = the generator's view, master = the driver's view.
// Revision : 1.0 - initial release
//============================================================================
interface imm_gen_pipe_if #(
    parameter int DATA_W = 64,
    parameter int ERR_W  = 16
);
    logic              InValid;
    logic              InReady;
    logic [31:0]       Instr;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] BusImm;
    logic [2:0]        ImmType;
    logic [31:0]       OutInstr;
    logic              BadOp;
    logic [ERR_W-1:0]  ErrCount;

    modport slave (
        input  InValid, Instr, OutReady,
        output InReady, OutValid, BusImm, ImmType, OutInstr, BadOp, ErrCount
    );

    modport master (
        output InValid, Instr, OutReady,
        input  InReady, OutValid, BusImm, ImmType, OutInstr, BadOp, ErrCount
    );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe_decode.sv
`default_nettype none
//============================================================================
// Module   : imm_decode
// Brief    : Combinational LEGv8 immediate extraction and extension.
//            First matching opcode wins; unknown opcodes flag bad_o.
// Config   : IMMGEN_MOVZ_EN enables MOVZ (type IW) decoding.
// Revision : 1.0 - initial release
//============================================================================
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [31:0]       instr_i,
    output logic [DATA_W-1:0] imm_o,
    output imm_type_e         type_o,
    output logic              bad_o
);

    // Rd/Rt field never contributes to an immediate
    logic w_unused;
    assign w_unused = ^instr_i[4:0];

`ifdef IMMGEN_MOVZ_EN
    // MOVZ builds the shifted half-word at 64 bits; on a 32-bit datapath
    // the upper two half-word positions cannot be represented.
    logic [63:0] w_movz_wide;
    logic        w_movz_fits;
    assign w_movz_wide = {48'd0, instr_i[20:5]} << {instr_i[22:21], 4'd0};
    assign w_movz_fits = (DATA_W == 64) || (instr_i[22] == 1'b0);
`endif

    // Priority decode of the opcode table
    always_comb begin
        imm_o  = '0;
        type_o = IMM_NONE;
        bad_o  = 1'b0;
        if (instr_i[31:26] == C_OP_B || instr_i[31:26] == C_OP_BL) begin
            imm_o  = {{(DATA_W-26){instr_i[25]}}, instr_i[25:0]};
            type_o = IMM_B;
        end else if (instr_i[31:24] == C_OP_CBZ || instr_i[31:24] == C_OP_CBNZ) begin
            imm_o  = {{(DATA_W-19){instr_i[23]}}, instr_i[23:5]};
            type_o = IMM_CB;
        end else if (instr_i[31:21] == C_OP_STUR || instr_i[31:21] == C_OP_LDUR) begin
            imm_o  = {{(DATA_W-9){instr_i[20]}}, instr_i[20:12]};
            type_o = IMM_D;
        end else if (instr_i[31:22] == C_OP_ADDI || instr_i[31:22] == C_OP_SUBI) begin
            imm_o  = {{(DATA_W-12){1'b0}}, instr_i[21:10]};
            type_o = IMM_I;
        end else if (instr_i[31:21] == C_OP_LSL || instr_i[31:21] == C_OP_LSR) begin
            imm_o  = {{(DATA_W-6){1'b0}}, instr_i[15:10]};
            type_o = IMM_SHAMT;
        end
`ifdef IMMGEN_MOVZ_EN
        else if (instr_i[31:23] == C_OP_MOVZ) begin
            if (w_movz_fits) begin
                imm_o  = w_movz_wide[DATA_W-1:0];
                type_o = IMM_IW;
            end else begin
                bad_o  = 1'b1;
            end
        end
`endif
        else begin
            bad_o = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
//============================================================================
// Module   : imm_gen_pipe
// Brief    : Pipelined LEGv8 immediate generator. One output register plus
//            one skid entry (2 words in flight), registered InReady and a
//            saturating unknown-opcode counter.
// Config   : IMMGEN_MOVZ_EN enables MOVZ decoding (type IW).
// Revision : 1.0 - initial release
//============================================================================
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ERR_W  = 16
) (
    input  logic           CLK,
    input  logic           Reset,
    imm_gen_pipe_if.slave  bus
);

    if (!data_w_legal(DATA_W)) begin : g_bad_data_w
        $error("imm_gen_pipe: DATA_W must be 32 or 64");
    end

    logic [DATA_W-1:0] w_dec_imm;
    imm_type_e         w_dec_type;
    logic              w_dec_bad;

    imm_decode #(.DATA_W(DATA_W)) u_decode (
        .instr_i (bus.Instr),
        .imm_o   (w_dec_imm),
        .type_o  (w_dec_type),
        .bad_o   (w_dec_bad)
    );

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_imm_q,   out_imm_d;
    imm_type_e         out_type_q,  out_type_d;
    logic [31:0]       out_instr_q, out_instr_d;
    logic              out_bad_q,   out_bad_d;

    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_imm_q,   skid_imm_d;
    imm_type_e         skid_type_q,  skid_type_d;
    logic [31:0]       skid_instr_q, skid_instr_d;
    logic              skid_bad_q,   skid_bad_d;

    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;

    logic w_accept;
    logic w_drain;

    // InReady depends only on the skid register, so OutReady never reaches it
    assign w_accept = bus.InValid & ~skid_valid_q;
    assign w_drain  = out_valid_q & bus.OutReady;

    // Next-state for output/skid stages; skid only fills while output stalls
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_type_d   = out_type_q;
        out_instr_d  = out_instr_q;
        out_bad_d    = out_bad_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_type_d  = skid_type_q;
        skid_instr_d = skid_instr_q;
        skid_bad_d   = skid_bad_q;
        err_cnt_d    = err_cnt_q;

        if (w_drain && skid_valid_q) begin
            // Older skid word advances; no accept is possible this cycle
            out_valid_d  = 1'b1;
            out_imm_d    = skid_imm_q;
            out_type_d   = skid_type_q;
            out_instr_d  = skid_instr_q;
            out_bad_d    = skid_bad_q;
            skid_valid_d = 1'b0;
        end else if (w_accept && (w_drain || !out_valid_q)) begin
            out_valid_d  = 1'b1;
            out_imm_d    = w_dec_imm;
            out_type_d   = w_dec_type;
            out_instr_d  = bus.Instr;
            out_bad_d    = w_dec_bad;
        end else if (w_accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = w_dec_imm;
            skid_type_d  = w_dec_type;
            skid_instr_d = bus.Instr;
            skid_bad_d   = w_dec_bad;
        end else if (w_drain) begin
            out_valid_d  = 1'b0;
        end

        if (w_accept && w_dec_bad && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    // Stage registers with synchronous reset discarding all held words
    always_ff @(posedge CLK) begin
        if (Reset) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_type_q   <= IMM_NONE;
            out_instr_q  <= '0;
            out_bad_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_type_q  <= IMM_NONE;
            skid_instr_q <= '0;
            skid_bad_q   <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_type_q   <= out_type_d;
            out_instr_q  <= out_instr_d;
            out_bad_q    <= out_bad_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_type_q  <= skid_type_d;
            skid_instr_q <= skid_instr_d;
            skid_bad_q   <= skid_bad_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign bus.InReady  = ~skid_valid_q;
    assign bus.OutValid = out_valid_q;
    assign bus.BusImm   = out_imm_q;
    assign bus.ImmType  = out_type_q;
    assign bus.OutInstr = out_instr_q;
    assign bus.BadOp    = out_bad_q;
    assign bus.ErrCount = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
//============================================================================
// Module   : tb_imm_gen_pipe
// Brief    : Scoreboard bench for imm_gen_pipe. A second instance with
//            ERR_W=2 shares the stimulus to observe counter saturation.
// Config   : IMMGEN_MOVZ_EN selects the MOVZ expectations.
// Revision : 1.0 - initial release
//============================================================================
module tb_imm_gen_pipe;

    logic CLK = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    imm_gen_pipe_if #(.DATA_W(64), .ERR_W(16)) bus  ();
    imm_gen_pipe_if #(.DATA_W(64), .ERR_W(2))  bus2 ();

    imm_gen_pipe #(.DATA_W(64), .ERR_W(16)) dut  (.CLK(CLK), .Reset(Reset), .bus(bus));
    imm_gen_pipe #(.DATA_W(64), .ERR_W(2))  dut2 (.CLK(CLK), .Reset(Reset), .bus(bus2));

    assign bus2.InValid  = bus.InValid;
    assign bus2.Instr    = bus.Instr;
    assign bus2.OutReady = bus.OutReady;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        bad;
        logic [31:0] ins;
    } exp_t;

    exp_t        sb[$];
    int unsigned exp_err  = 0;
    int unsigned exp_err2 = 0;
    int          n_vec    = 0;
    int          n_err    = 0;
    bit          seen_rst = 0;
    bit          rst_prev = 0;
    bit          rnd_done = 0;

    // Reference: field value by arithmetic, two's complement via subtraction
    function automatic exp_t model(input logic [31:0] w);
        exp_t        e;
        logic [63:0] v;
        e.imm = 64'd0; e.typ = 3'd0; e.bad = 1'b0; e.ins = w;
        if ((w >> 26) == 32'h05 || (w >> 26) == 32'h25) begin
            v = 64'(w[25:0]);
            if (v >= (64'd1 << 25)) v = v - (64'd1 << 26);
            e.imm = v; e.typ = 3'd1;
        end else if ((w >> 24) == 32'hB4 || (w >> 24) == 32'hB5) begin
            v = 64'(w[23:5]);
            if (v >= (64'd1 << 18)) v = v - (64'd1 << 19);
            e.imm = v; e.typ = 3'd2;
        end else if ((w >> 21) == 32'h7C0 || (w >> 21) == 32'h7C2) begin
            v = 64'(w[20:12]);
            if (v >= (64'd1 << 8)) v = v - (64'd1 << 9);
            e.imm = v; e.typ = 3'd3;
        end else if ((w >> 22) == 32'h244 || (w >> 22) == 32'h344) begin
            e.imm = 64'(w[21:10]); e.typ = 3'd4;
        end else if ((w >> 21) == 32'h69B || (w >> 21) == 32'h69A) begin
            e.imm = 64'(w[15:10]); e.typ = 3'd5;
        end
`ifdef IMMGEN_MOVZ_EN
        else if ((w >> 23) == 32'h1A5) begin
            e.imm = 64'(w[20:5]) * (64'd1 << (16 * int'(w[22:21])));
            e.typ = 3'd6;
        end
`endif
        else begin
            e.bad = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: r[31:26] = ($urandom % 2) ? 6'b100101 : 6'b000101;
            1: r[31:24] = ($urandom % 2) ? 8'hB5 : 8'hB4;
            2: r[31:21] = ($urandom % 2) ? 11'h7C2 : 11'h7C0;
            3: r[31:22] = ($urandom % 2) ? 10'h344 : 10'h244;
            4: r[31:21] = ($urandom % 2) ? 11'h69B : 11'h69A;
            5: r[31:23] = 9'h1A5;
            default: ;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Present one word, wait (bounded) for its handshake, record expectation
    task automatic send_exp(input logic [31:0] ins, input logic [63:0] imm,
                            input logic [2:0] typ, input logic bad);
        exp_t e;
        bit   ok;
        e.imm = imm; e.typ = typ; e.bad = bad; e.ins = ins;
        bus.InValid = 1'b1;
        bus.Instr   = ins;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (bus.InReady === 1'b1 && !Reset) begin ok = 1; break; end
        end
        @(posedge CLK); #1;
        if (ok) sb.push_back(e);
        else begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: got no InReady expected handshake for %h", ins);
        end
        bus.InValid = 1'b0;
    endtask

    task automatic send_model(input logic [31:0] ins);
        exp_t e;
        e = model(ins);
        send_exp(ins, e.imm, e.typ, e.bad);
    endtask

    // Monitor: compares the DUT against the scoreboard every cycle
    always @(negedge CLK) begin
        exp_t m;
        if (seen_rst) begin
            if (rst_prev) begin
                chk("rst_busimm",   bus.BusImm,   64'd0);
                chk("rst_immtype",  64'(bus.ImmType),  64'd0);
                chk("rst_outinstr", 64'(bus.OutInstr), 64'd0);
                chk("rst_badop",    64'(bus.BadOp),    64'd0);
            end
            chk("out_valid",  64'(bus.OutValid), 64'(sb.size() > 0));
            chk("in_ready",   64'(bus.InReady),  64'(sb.size() < 2));
            chk("err_count",  64'(bus.ErrCount),  64'(exp_err));
            chk("err_sat_w2", 64'(bus2.ErrCount), 64'(exp_err2));
            if (bus.OutValid === 1'b1 && sb.size() > 0) begin
                chk("busimm",   bus.BusImm,         sb[0].imm);
                chk("immtype",  64'(bus.ImmType),   64'(sb[0].typ));
                chk("outinstr", 64'(bus.OutInstr),  64'(sb[0].ins));
                chk("badop",    64'(bus.BadOp),     64'(sb[0].bad));
            end
        end
        if (Reset) begin
            sb.delete();
            exp_err  = 0;
            exp_err2 = 0;
            rst_prev = 1;
            seen_rst = 1;
        end else begin
            rst_prev = 0;
            if (bus.InValid === 1'b1 && bus.InReady === 1'b1) begin
                m = model(bus.Instr);
                if (m.bad) begin
                    if (exp_err  < 65535) exp_err++;
                    if (exp_err2 < 3)     exp_err2++;
                end
            end
            if (bus.OutValid === 1'b1 && bus.OutReady === 1'b1 && sb.size() > 0)
                void'(sb.pop_front());
        end
    end

    initial begin
        bus.InValid  = 1'b0;
        bus.Instr    = 32'd0;
        bus.OutReady = 1'b1;
        Reset        = 1'b1;
        repeat (3) @(posedge CLK);
        #1 Reset = 1'b0;

        // B with imm26 = -1
        send_exp(32'h17FF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0);
        // CBZ imm19=0x40000 then LDUR imm9=0x0FF, back-to-back
        send_exp({8'hB4, 19'h40000, 5'd3}, 64'hFFFF_FFFF_FFFC_0000, 3'd2, 1'b0);
        send_exp({11'h7C2, 9'h0FF, 2'b00, 5'd1, 5'd2}, 64'h0000_0000_0000_00FF, 3'd3, 1'b0);
        repeat (2) @(posedge CLK);
        #1;

        // Stall output; third ADDI waits in front of a full skid entry
        bus.OutReady = 1'b0;
        fork
            begin
                send_exp({10'h244, 12'd5, 10'd0}, 64'd5, 3'd4, 1'b0);
                send_exp({10'h244, 12'd6, 10'd0}, 64'd6, 3'd4, 1'b0);
                send_exp({10'h244, 12'd7, 10'd0}, 64'd7, 3'd4, 1'b0);
            end
            begin
                repeat (8) @(posedge CLK);
                #1 bus.OutReady = 1'b1;
            end
        join
        repeat (3) @(posedge CLK);
        #1;

        // Unknown opcode: counter 1,2,3 then holds at 3 in the ERR_W=2 copy
        for (int i = 0; i < 4; i++) send_exp(32'hFFFF_FFFF, 64'd0, 3'd0, 1'b1);

        // MOVZ hw=2 imm16=0xBEEF
`ifdef IMMGEN_MOVZ_EN
        send_exp({9'h1A5, 2'd2, 16'hBEEF, 5'd4}, 64'h0000_BEEF_0000_0000, 3'd6, 1'b0);
`else
        send_exp({9'h1A5, 2'd2, 16'hBEEF, 5'd4}, 64'd0, 3'd0, 1'b1);
`endif
        repeat (2) @(posedge CLK);
        #1;

        // Reset with both entries occupied and output stalled
        bus.OutReady = 1'b0;
        send_exp({10'h344, 12'd1, 10'd0}, 64'd1, 3'd4, 1'b0);
        send_exp({10'h344, 12'd2, 10'd0}, 64'd2, 3'd4, 1'b0);
        @(posedge CLK);
        #1 Reset = 1'b1;
        @(posedge CLK);
        #1 Reset = 1'b0;
        bus.OutReady = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Randomised traffic with random back-pressure
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge CLK); #1;
                    end
                    send_model(rand_instr());
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge CLK);
                    #1 bus.OutReady = ($urandom_range(0, 3) != 0);
                end
            end
        join

        // Drain everything still held
        bus.OutReady = 1'b1;
        for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge CLK);
        @(negedge CLK);
        if (sb.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL drain_timeout: got %0d words held expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
